// File: rtl/tile_renderer_scroll.sv
// tile_renderer_scroll: tile renderer with fine X/Y scroll and a page table.
// Define BORDER_EN to add a border colour outside the tiled area.
module tile_renderer_scroll #(
   parameter int COLS     = 32,
   parameter int ROWS     = 28,
   parameter int ATTR_OFS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic        display_on,
   input  logic [7:0]  page_base,
   input  logic [2:0]  scroll_x,
   input  logic [2:0]  scroll_y,
`ifdef BORDER_EN
   input  logic [3:0]  border_color,
`endif
   output logic [15:0] ram_addr,
   input  logic [7:0]  ram_read,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic [3:0]  rgb
);

   logic [7:0]  page_l;
   logic [2:0]  sx_l;
   logic [2:0]  sy_l;
   logic [15:0] row_base;
   logic [7:0]  char_q;
   logic [7:0]  attr_q;
   logic [7:0]  next_char;
   logic [7:0]  next_attr;
   logic        fetching;
   logic        line_ok;

   logic [7:0]  vy_in;
   logic [4:0]  row_in;
   logic [7:0]  vy;
   logic [4:0]  row;
   logic [7:0]  xs;
   logic [2:0]  phase;
   logic [5:0]  col_raw;
   logic [4:0]  col;
   logic [7:0]  k;
   logic [15:0] cell_addr;
   logic        unused_vpos;

   // The page-table read at k=0 uses the scroll value being latched now.
   assign vy_in     = vpos[7:0] + {5'd0, scroll_y};
   assign row_in    = 5'({1'b0, vy_in[7:3]} % 6'(ROWS));
   assign vy        = vpos[7:0] + {5'd0, sy_l};
   assign row       = 5'({1'b0, vy[7:3]} % 6'(ROWS));
   assign xs        = hpos[7:0] + {5'd0, sx_l};
   assign phase     = xs[2:0];
   assign col_raw   = {1'b0, xs[7:3]} + 6'd1;
   assign col       = 5'(col_raw % 6'(COLS));
   assign k         = hpos[7:0];
   assign cell_addr = row_base + {11'd0, col};
   assign rom_addr  = {char_q, vy[2:0]};
   assign unused_vpos = vpos[8];

   // Row-pointer fetch in hblank, one-cell-ahead tile fetch in active video.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr  <= 16'h0000;
         row_base  <= 16'h0000;
         char_q    <= 8'h00;
         attr_q    <= 8'h00;
         next_char <= 8'h00;
         next_attr <= 8'h00;
         page_l    <= 8'h00;
         sx_l      <= 3'd0;
         sy_l      <= 3'd0;
         fetching  <= 1'b0;
         line_ok   <= 1'b0;
      end else if (hpos[8]) begin
         if (k == 8'd0) begin
            page_l   <= page_base;
            sx_l     <= scroll_x;
            sy_l     <= scroll_y;
            ram_addr <= {page_base, row_in, 3'b000};
            fetching <= 1'b1;
         end else if (fetching) begin
            unique case (k)
               8'd2:  row_base[7:0]  <= ram_read;
               8'd3:  ram_addr       <= {page_l, row, 3'b001};
               8'd5:  row_base[15:8] <= ram_read;
               8'd8:  ram_addr       <= row_base;
               8'd10: next_char      <= ram_read;
               8'd11: ram_addr       <= row_base + 16'(ATTR_OFS);
               8'd13: next_attr      <= ram_read;
               8'd15: begin
                  char_q   <= next_char;
                  attr_q   <= next_attr;
                  line_ok  <= 1'b1;
                  fetching <= 1'b0;
               end
               default: ;
            endcase
         end
      end else begin
         unique case (phase)
            3'd0: ram_addr  <= cell_addr;
            3'd2: next_char <= ram_read;
            3'd3: ram_addr  <= cell_addr + 16'(ATTR_OFS);
            3'd5: next_attr <= ram_read;
            3'd7: begin
               char_q <= next_char;
               attr_q <= next_attr;
            end
            default: ;
         endcase
      end
   end

   // Pixel colour: glyph bit picks the attr nibble; dark until a line is fetched.
   always_comb begin
      rgb = 4'h0;
      if (display_on && line_ok) begin
         rgb = rom_data[~phase] ? attr_q[3:0] : attr_q[7:4];
      end
`ifdef BORDER_EN
      if (display_on &&
          (hpos >= 9'(COLS * 8) || vpos >= 9'(ROWS * 8))) begin
         rgb = border_color;
      end
`endif
   end

endmodule

// File: tb/tb_tile_renderer_scroll.sv
// Bench for tile_renderer_scroll: random tile maps and scrolls compared
// against a tile-map model of what each pixel should show.
module tb_tile_renderer_scroll;
   localparam int COLS     = 32;
   localparam int ROWS     = 28;
   localparam int ATTR_OFS = 32;
   localparam int HB       = 48;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  hpos;
   logic [8:0]  vpos;
   logic        display_on;
   logic [7:0]  page_base;
   logic [2:0]  scroll_x;
   logic [2:0]  scroll_y;
   logic [15:0] ram_addr;
   logic [7:0]  ram_read;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  rgb;
`ifdef BORDER_EN
   logic [3:0]  border_color;
`endif

   logic [7:0] mem [0:65535];
   logic [7:0] rom [0:2047];
   int checks = 0;
   int errors = 0;
   logic [7:0] m_pg;
   logic [2:0] m_sx;
   logic [2:0] m_sy;
   bit blank_all = 1'b0;

   tile_renderer_scroll #(
      .COLS(COLS), .ROWS(ROWS), .ATTR_OFS(ATTR_OFS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .hpos(hpos),
      .vpos(vpos),
      .display_on(display_on),
      .page_base(page_base),
      .scroll_x(scroll_x),
      .scroll_y(scroll_y),
`ifdef BORDER_EN
      .border_color(border_color),
`endif
      .ram_addr(ram_addr),
      .ram_read(ram_read),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .rgb(rgb)
   );

   always #5 clk = ~clk;

   // RAM with one register stage: data for an address set at edge t
   // is seen by the renderer at edge t+2.
   always @(posedge clk) ram_read <= mem[ram_addr];
   assign rom_data = rom[rom_addr];

   task automatic drive(input int h, input int v);
      @(posedge clk);
      #1;
      hpos = 9'(h);
      vpos = 9'(v);
      display_on = ~hpos[8] & ~blank_all;
      @(negedge clk);
   endtask

   // What the screen shows at (h, v) given the latched page and scroll.
   function automatic logic [3:0] model_pix(input int h, input int v);
      int xs, vy, row, t;
      logic [15:0] rb;
      logic [7:0] ch, at, g;
      if (blank_all) return 4'h0;
`ifdef BORDER_EN
      if (h >= COLS * 8 || v >= ROWS * 8) return border_color;
`endif
      xs  = (h + m_sx) % 256;
      vy  = (v + m_sy) % 256;
      row = (vy / 8) % ROWS;
      rb  = {mem[{m_pg, 5'(row), 3'b001}], mem[{m_pg, 5'(row), 3'b000}]};
      t   = (xs / 8) % COLS;
      ch  = mem[16'(rb + t)];
      at  = mem[16'(rb + t + ATTR_OFS)];
      g   = rom[{ch, 3'(vy % 8)}];
      return g[7 - (xs % 8)] ? at[3:0] : at[7:4];
   endfunction

   task automatic hblank(input int v);
      for (int k = 0; k < HB; k++) begin
         drive(256 + k, v);
         if (k == 0) begin
            m_pg = page_base;
            m_sx = scroll_x;
            m_sy = scroll_y;
         end
      end
   endtask

   task automatic active(input int v, input bit perturb, input int h0);
      int xs;
      logic [3:0] exp_rgb;
      for (int h = h0; h < 256; h++) begin
         if (perturb && h == 128) begin
            page_base = 8'($urandom);
            scroll_x  = 3'($urandom);
            scroll_y  = 3'($urandom);
         end
         drive(h, v);
         xs = (h + m_sx) % 256;
         if (!(m_sx != 0 && xs >= 8 && xs < 16)) begin
            exp_rgb = model_pix(h, v);
            checks++;
            if (rgb !== exp_rgb) begin
               errors++;
               $display("FAIL pixel h=%0d v=%0d: rgb=%h expected %h",
                        h, v, rgb, exp_rgb);
            end
         end
      end
   endtask

   task automatic line(input int v, input bit perturb);
      hblank(v);
      active(v, perturb, 0);
   endtask

   task automatic test_reset();
      int nz;
      drive(101, 0);
      reset = 1'b0;
      checks++;
      if (ram_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_addr: ram_addr=%h expected 0000", ram_addr);
      end
      checks++;
      if (rgb !== 4'h0) begin
         errors++;
         $display("FAIL reset_rgb: rgb=%h expected 0", rgb);
      end
      nz = 0;
      for (int h = 102; h < 256; h++) begin
         drive(h, 0);
         if (rgb !== 4'h0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL reset_dark: %0d lit pixels, expected 0", nz);
      end
   endtask

   task automatic test_glyph();
      logic [7:0] pat;
      logic [3:0] exp_rgb;
      pat = 8'b0111_0010;
      page_base = 8'h10;
      scroll_x = 3'd0;
      scroll_y = 3'd0;
      mem[16'h1000] = 8'h00;
      mem[16'h1001] = 8'h20;
      mem[16'h2000] = 8'h41;
      mem[16'h2020] = 8'h1F;
      rom[11'h208] = pat;
      for (int k = 0; k < HB; k++) begin
         drive(256 + k, 0);
         if (k == 0) begin
            m_pg = page_base;
            m_sx = scroll_x;
            m_sy = scroll_y;
         end
         if (k == 1 || k == 4 || k == 9 || k == 12) begin
            checks++;
            if (ram_addr !== (k == 1 ? 16'h1000 : k == 4 ? 16'h1001 :
                              k == 9 ? 16'h2000 : 16'h2020)) begin
               errors++;
               $display("FAIL hblank_addr k=%0d: ram_addr=%h", k, ram_addr);
            end
         end
      end
      for (int h = 0; h < 256; h++) begin
         drive(h, 0);
         if (h < 8) begin
            checks++;
            if (rom_addr !== 11'h208) begin
               errors++;
               $display("FAIL glyph_rom h=%0d: rom_addr=%h expected 208",
                        h, rom_addr);
            end
            exp_rgb = pat[7 - h] ? 4'hF : 4'h1;
            checks++;
            if (rgb !== exp_rgb) begin
               errors++;
               $display("FAIL glyph_rgb h=%0d: rgb=%h expected %h",
                        h, rgb, exp_rgb);
            end
         end
      end
   endtask

   task automatic test_scroll_x();
      logic [15:0] rb;
      logic [3:0] exp_rgb;
      int sx, xs, row;
      for (int i = 0; i < 2; i++) begin
         sx = (i == 0) ? 3 : 7;
         scroll_x  = 3'(sx);
         scroll_y  = 3'($urandom);
         page_base = 8'($urandom);
         hblank(40);
         row = (((40 + m_sy) % 256) / 8) % ROWS;
         rb  = {mem[{m_pg, 5'(row), 3'b001}], mem[{m_pg, 5'(row), 3'b000}]};
         for (int h = 0; h < 256; h++) begin
            drive(h, 40);
            if (h == 249 - sx) begin
               checks++;
               if (ram_addr !== rb) begin
                  errors++;
                  $display("FAIL col_wrap sx=%0d: ram_addr=%h expected %h",
                           sx, ram_addr, rb);
               end
            end
            xs = (h + sx) % 256;
            if (!(xs >= 8 && xs < 16)) begin
               exp_rgb = model_pix(h, 40);
               checks++;
               if (rgb !== exp_rgb) begin
                  errors++;
                  $display("FAIL scroll_pix sx=%0d h=%0d: rgb=%h expected %h",
                           sx, h, rgb, exp_rgb);
               end
            end
         end
      end
   endtask

   task automatic test_scroll_y();
      logic [2:0] yofs;
      page_base = 8'($urandom);
      scroll_x  = 3'd0;
      scroll_y  = 3'd5;
      for (int k = 0; k < HB; k++) begin
         drive(256 + k, 3);
         if (k == 0) begin
            m_pg = page_base;
            m_sx = scroll_x;
            m_sy = scroll_y;
         end
         if (k == 1) begin
            checks++;
            if (ram_addr !== {m_pg, 5'd1, 3'b000}) begin
               errors++;
               $display("FAIL scroll_y_row: ram_addr=%h expected %h",
                        ram_addr, {m_pg, 5'd1, 3'b000});
            end
         end
      end
      drive(0, 3);
      yofs = rom_addr[2:0];
      checks++;
      if (yofs !== 3'd0) begin
         errors++;
         $display("FAIL scroll_y_yofs: yofs=%0d expected 0", yofs);
      end
      active(3, 1'b0, 1);
   endtask

   task automatic test_row_wrap();
      page_base = 8'($urandom);
      scroll_x  = 3'($urandom);
      scroll_y  = 3'd0;
      for (int k = 0; k < HB; k++) begin
         drive(256 + k, 224);
         if (k == 0) begin
            m_pg = page_base;
            m_sx = scroll_x;
            m_sy = scroll_y;
         end
         if (k == 1) begin
            checks++;
            if (ram_addr !== {m_pg, 8'h00}) begin
               errors++;
               $display("FAIL row_wrap: ram_addr=%h expected %h",
                        ram_addr, {m_pg, 8'h00});
            end
         end
      end
      active(224, 1'b0, 0);
   endtask

   task automatic test_random();
      int v0;
      v0 = $urandom_range(0, 255);
      for (int i = 0; i < 12; i++) begin
         page_base = 8'($urandom);
         scroll_x  = 3'($urandom);
         scroll_y  = 3'($urandom);
         line((v0 + i) % 256, 1'b1);
      end
   endtask

   task automatic test_display_off();
      blank_all = 1'b1;
      line(50, 1'b0);
      blank_all = 1'b0;
   endtask

   task automatic test_reset_midline();
      int nz;
      line(10, 1'b0);
      hblank(11);
      for (int h = 0; h <= 100; h++) drive(h, 11);
      reset = 1'b1;
      drive(101, 11);
      reset = 1'b0;
      checks++;
      if (ram_addr !== 16'h0000 || rgb !== 4'h0) begin
         errors++;
         $display("FAIL midline_reset: ram_addr=%h rgb=%h expected 0000/0",
                  ram_addr, rgb);
      end
      nz = 0;
      for (int h = 102; h < 256; h++) begin
         drive(h, 11);
         if (rgb !== 4'h0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL midline_dark: %0d lit pixels, expected 0", nz);
      end
      line(12, 1'b0);
   endtask

   task automatic test_reset_hblank();
      int nz;
      line(20, 1'b0);
      for (int k = 0; k < HB; k++) begin
         drive(256 + k, 21);
         if (k == 4) reset = 1'b1;
         if (k == 5) reset = 1'b0;
         if (k == 20) begin
            checks++;
            if (ram_addr !== 16'h0000) begin
               errors++;
               $display("FAIL hblank_reset_addr: ram_addr=%h expected 0000",
                        ram_addr);
            end
         end
      end
      nz = 0;
      for (int h = 0; h < 256; h++) begin
         drive(h, 21);
         if (rgb !== 4'h0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL hblank_reset_dark: %0d lit pixels, expected 0", nz);
      end
      line(22, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
`ifdef BORDER_EN
      border_color = 4'h9;
`endif
      reset      = 1'b1;
      hpos       = 9'd100;
      vpos       = 9'd0;
      display_on = 1'b1;
      page_base  = 8'h00;
      scroll_x   = 3'd0;
      scroll_y   = 3'd0;
      m_pg       = 8'h00;
      m_sx       = 3'd0;
      m_sy       = 3'd0;
      test_reset();
      test_glyph();
      test_scroll_x();
      test_scroll_y();
      test_row_wrap();
      test_random();
      test_display_off();
      test_reset_midline();
      test_reset_hblank();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
